// File: rtl/udp_rx_echo.sv
// rtl/udp_rx_echo.sv - single-packet UDP payload capture and echo engine
//
// Purpose: stores one received UDP payload in a byte buffer, then replays it
//   through the stack's app transmit handshake so the peer gets its own bytes
//   back. Optional feature macro: UDP_ECHO_LEN_CHECK_EN (drop packets whose
//   captured byte count disagrees with the UDP length field, or that overflowed).
//
// Ports:
//   rgmii_clk           in   sole clock
//   rstn                in   asynchronous active-low reset
//   udp_rec_data_valid  in   received payload byte strobe (contiguous per packet)
//   udp_rec_rdata       in   received payload byte
//   udp_rec_data_length in   UDP length field (header + payload)
//   udp_send_ack        in   stack accepted the request, payload may follow
//   mac_send_end        in   frame fully transmitted
//   app_data_request    out  transmit request
//   app_data_length     out  payload bytes to send
//   app_data_in_valid   out  payload byte strobe
//   app_data_in         out  payload byte
//   rx_pkt_cnt          out  packets accepted for echo (saturating)
//   drop_cnt            out  packets dropped (saturating)
//   trunc               out  sticky: some packet exceeded MAX_LEN
module udp_rx_echo #(
  parameter int unsigned MAX_LEN     = 1472,
  parameter int unsigned ADDR_W      = 11,
  parameter logic [31:0] ACK_TIMEOUT = 32'd125_000
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        udp_rec_data_valid,
  input  logic [7:0]  udp_rec_rdata,
  input  logic [15:0] udp_rec_data_length,
  input  logic        udp_send_ack,
  input  logic        mac_send_end,
  output logic        app_data_request,
  output logic [15:0] app_data_length,
  output logic        app_data_in_valid,
  output logic [7:0]  app_data_in,
  output logic [15:0] rx_pkt_cnt,
  output logic [15:0] drop_cnt,
  output logic        trunc
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, RECV, REQ, SEND, DONE} state_t;

  state_t      state;
  logic [15:0] byte_cnt;
  logic [15:0] rd_cnt;
  logic [31:0] ack_timer;
  logic        valid_d;
  logic        skip_pkt;
  logic [7:0]  mem [0:(1<<ADDR_W)-1];
  logic [7:0]  rd_data;

  logic              rec_rise;
  logic              busy_rise;
  logic              capture_start;
  logic              recv_wr;
  logic              recv_end;
  logic              ack_expire;
  logic              len_bad;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [1:0]        drop_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign rec_rise  = udp_rec_data_valid & ~valid_d;
  // A packet that starts while an echo is pending is ignored as a whole.
  assign busy_rise = rec_rise & ((state == REQ) | (state == SEND) | (state == DONE));
  // skip_pkt stops IDLE from capturing the tail of a packet that began while busy.
  assign capture_start = (state == IDLE) & udp_rec_data_valid & ~skip_pkt;
  assign recv_wr       = (state == RECV) & udp_rec_data_valid & (byte_cnt < MAX_LEN_W);
  assign recv_end      = (state == RECV) & ~udp_rec_data_valid;
  assign ack_expire    = (state == REQ) & ~udp_send_ack & (ack_timer == ACK_TIMEOUT - 32'd1);

  assign wr_en   = capture_start | recv_wr;
  assign wr_addr = capture_start ? '0 : byte_cnt[ADDR_W-1:0];
  assign rd_en   = (state == SEND);

  // An ignored packet start and an ack timeout can coincide in REQ.
  assign drop_inc = 2'(busy_rise) + 2'(ack_expire) + 2'(recv_end & len_bad);

`ifdef UDP_ECHO_LEN_CHECK_EN
  logic [15:0] exp_len;
  logic        pkt_trunc;

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      exp_len   <= '0;
      pkt_trunc <= 1'b0;
    end else if (capture_start) begin
      exp_len   <= udp_rec_data_length;
      pkt_trunc <= 1'b0;
    end else if ((state == RECV) && udp_rec_data_valid && !recv_wr) begin
      pkt_trunc <= 1'b1;
    end
  end

  assign len_bad = pkt_trunc | (byte_cnt != exp_len - 16'd8);
`else
  logic unused_len;
  assign unused_len = ^udp_rec_data_length;
  assign len_bad    = 1'b0;
`endif

  // Buffer: no reset, contents are don't-care after an abort.
  always_ff @(posedge rgmii_clk) begin
    if (wr_en) mem[wr_addr] <= udp_rec_rdata;
    if (rd_en) rd_data <= mem[rd_cnt[ADDR_W-1:0]];
  end

  // rd_data has no reset; gating keeps the output at zero outside strobes.
  assign app_data_in = app_data_in_valid ? rd_data : 8'h00;

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      byte_cnt          <= '0;
      rd_cnt            <= '0;
      ack_timer         <= '0;
      valid_d           <= 1'b0;
      skip_pkt          <= 1'b0;
      app_data_request  <= 1'b0;
      app_data_length   <= '0;
      app_data_in_valid <= 1'b0;
      rx_pkt_cnt        <= '0;
      drop_cnt          <= '0;
      trunc             <= 1'b0;
    end else begin
      valid_d           <= udp_rec_data_valid;
      app_data_in_valid <= 1'b0;
      drop_cnt          <= sat_add(drop_cnt, drop_inc);

      if (!udp_rec_data_valid) skip_pkt <= 1'b0;
      else if (busy_rise)      skip_pkt <= 1'b1;

      case (state)
        IDLE: begin
          if (capture_start) begin
            byte_cnt <= 16'd1;
            state    <= RECV;
          end
        end
        RECV: begin
          if (recv_wr) begin
            byte_cnt <= byte_cnt + 16'd1;
          end else if (udp_rec_data_valid) begin
            trunc <= 1'b1;
          end else if (len_bad) begin
            state <= IDLE;
          end else begin
            app_data_length  <= byte_cnt;
            rx_pkt_cnt       <= sat_add(rx_pkt_cnt, 2'd1);
            ack_timer        <= '0;
            app_data_request <= 1'b1;
            state            <= REQ;
          end
        end
        REQ: begin
          if (udp_send_ack) begin
            app_data_request <= 1'b0;
            rd_cnt           <= '0;
            state            <= SEND;
          end else if (ack_expire) begin
            app_data_request <= 1'b0;
            state            <= IDLE;
          end else begin
            ack_timer <= ack_timer + 32'd1;
          end
        end
        SEND: begin
          // Read issued this cycle shows up as a strobe next cycle.
          app_data_in_valid <= 1'b1;
          rd_cnt            <= rd_cnt + 16'd1;
          if (rd_cnt == app_data_length - 16'd1) state <= DONE;
        end
        DONE: begin
          if (mac_send_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_echo.sv
// tb/tb_udp_rx_echo.sv - self-checking bench for udp_rx_echo
module tb_udp_rx_echo;

  localparam int MAX = 1472;
  localparam int TMO = 200;

  typedef logic [7:0] bq_t[$];

  logic        rgmii_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        udp_rec_data_valid = 1'b0;
  logic [7:0]  udp_rec_rdata = 8'h00;
  logic [15:0] udp_rec_data_length = 16'h0000;
  logic        udp_send_ack = 1'b0;
  logic        mac_send_end = 1'b0;
  logic        app_data_request;
  logic [15:0] app_data_length;
  logic        app_data_in_valid;
  logic [7:0]  app_data_in;
  logic [15:0] rx_pkt_cnt;
  logic [15:0] drop_cnt;
  logic        trunc;

  udp_rx_echo #(
    .MAX_LEN(MAX),
    .ADDR_W(11),
    .ACK_TIMEOUT(32'(TMO))
  ) dut (
    .rgmii_clk(rgmii_clk),
    .rstn(rstn),
    .udp_rec_data_valid(udp_rec_data_valid),
    .udp_rec_rdata(udp_rec_rdata),
    .udp_rec_data_length(udp_rec_data_length),
    .udp_send_ack(udp_send_ack),
    .mac_send_end(mac_send_end),
    .app_data_request(app_data_request),
    .app_data_length(app_data_length),
    .app_data_in_valid(app_data_in_valid),
    .app_data_in(app_data_in),
    .rx_pkt_cnt(rx_pkt_cnt),
    .drop_cnt(drop_cnt),
    .trunc(trunc)
  );

  always #5 rgmii_clk = ~rgmii_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cyc = -100;
  int ack_delay = 5;
  bit ack_en = 1'b1;

  // Model state: bytes and burst lengths the peer must see, expected counters.
  bq_t  exp_q;
  int   exp_blen[$];
  int   exp_rx = 0;
  int   exp_drop = 0;
  bit   exp_trunc = 1'b0;

  // Observed burst information from the compare process.
  bit         in_burst = 1'b0;
  int         bcnt = 0;
  int         cur_exp = 0;
  int         last_blen = -1;
  logic [7:0] last_first = 8'h00;
  logic [7:0] last_last = 8'h00;

  always @(posedge rgmii_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Packet rules: busy -> dropped; else stored (first MAX bytes), echoed if acked.
  function automatic void model_rx(input bq_t d, input int lf, input bit busy, input bit acked);
    int n;
    n = d.size();
    if (busy) begin
      exp_drop++;
      return;
    end
    if (n > MAX) exp_trunc = 1'b1;
`ifdef UDP_ECHO_LEN_CHECK_EN
    if (n > MAX || n != lf - 8) begin
      exp_drop++;
      return;
    end
`else
    if (lf < 0) exp_drop = exp_drop;
`endif
    exp_rx++;
    if (acked) begin
      for (int i = 0; i < n && i < MAX; i++) exp_q.push_back(d[i]);
      exp_blen.push_back(n < MAX ? n : MAX);
    end else begin
      exp_drop++;
    end
  endfunction

  // Compare process: every strobe checked against the model.
  always @(negedge rgmii_clk) begin
    if (!rstn) begin
      in_burst = 1'b0;
    end else if (app_data_in_valid) begin
      if (!in_burst) begin
        in_burst = 1'b1;
        bcnt = 0;
        chk("burst_expected", exp_blen.size() > 0, 1);
        cur_exp = (exp_blen.size() > 0) ? exp_blen.pop_front() : 0;
        chk("first_strobe_latency", cyc - ack_cyc, 2);
        last_first = app_data_in;
      end
      bcnt++;
      last_last = app_data_in;
      chk("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("echo_byte", app_data_in, exp_q.pop_front());
      chk("strobe_length_field", app_data_length, cur_exp);
      chk("request_low_in_send", app_data_request, 0);
    end else if (in_burst) begin
      in_burst = 1'b0;
      chk("burst_len", bcnt, cur_exp);
      last_blen = bcnt;
    end
  end

  // Stack stand-in: ack after ack_delay cycles, mac_send_end after the burst.
  initial begin
    int k;
    bit seen;
    forever begin
      @(negedge rgmii_clk);
      if (app_data_request && ack_en) begin
        repeat (ack_delay) @(posedge rgmii_clk);
        #1 udp_send_ack = 1'b1;
        ack_cyc = cyc;
        @(posedge rgmii_clk);
        #1 udp_send_ack = 1'b0;
        seen = 1'b0;
        k = 0;
        while (k < 3000 && !(seen && !app_data_in_valid)) begin
          @(negedge rgmii_clk);
          if (app_data_in_valid) seen = 1'b1;
          k++;
        end
        repeat (3) @(posedge rgmii_clk);
        #1 mac_send_end = 1'b1;
        @(posedge rgmii_clk);
        #1 mac_send_end = 1'b0;
      end
    end
  end

  task automatic send_pkt(input bq_t d, input logic [15:0] lf);
    foreach (d[i]) begin
      @(posedge rgmii_clk);
      #1;
      udp_rec_data_valid  = 1'b1;
      udp_rec_rdata       = d[i];
      udp_rec_data_length = lf;
    end
    @(posedge rgmii_clk);
    #1;
    udp_rec_data_valid  = 1'b0;
    udp_rec_rdata       = 8'h00;
    udp_rec_data_length = 16'h0000;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    repeat (4) @(negedge rgmii_clk);
    while (k < 5000 && (exp_q.size() != 0 || app_data_in_valid || app_data_request)) begin
      @(negedge rgmii_clk);
      k++;
    end
    chk({name, "_echo_complete"}, k < 5000, 1);
    repeat (12) @(negedge rgmii_clk);
  endtask

  task automatic wait_strobe(input string name);
    int k;
    k = 0;
    while (k < 200 && !app_data_in_valid) begin
      @(negedge rgmii_clk);
      k++;
    end
    chk({name, "_strobe_seen"}, app_data_in_valid, 1);
  endtask

  task automatic check_cnt(input string name);
    chk({name, "_rx_pkt_cnt"}, rx_pkt_cnt, exp_rx);
    chk({name, "_drop_cnt"}, drop_cnt, exp_drop);
    chk({name, "_trunc"}, trunc, exp_trunc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t   p;
    string s;
    int    k;

    // Reset state
    repeat (3) @(negedge rgmii_clk);
    chk("rst_request", app_data_request, 0);
    chk("rst_valid", app_data_in_valid, 0);
    chk("rst_data", app_data_in, 0);
    chk("rst_length", app_data_length, 0);
    chk("rst_rx_pkt_cnt", rx_pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_trunc", trunc, 0);
    #2 rstn = 1'b1;
    repeat (3) @(negedge rgmii_clk);

    // 1: 20-byte text payload, ack 5 cycles after request
    s = "www.meyesemi.com   \n";
    p = {};
    for (int i = 0; i < s.len(); i++) p.push_back(s[i]);
    model_rx(p, 28, 1'b0, 1'b1);
    send_pkt(p, 16'd28);
    wait_done("t1");
    chk("t1_rx_literal", rx_pkt_cnt, 1);
    chk("t1_len_literal", app_data_length, 20);
    chk("t1_blen_literal", last_blen, 20);
    chk("t1_first_byte", last_first, 8'h77);
    chk("t1_last_byte", last_last, 8'h0A);
    chk("t1_request_idle", app_data_request, 0);
    check_cnt("t1");

    // 2: 1500-byte payload, truncated to MAX
    p = {};
    for (int i = 0; i < 1500; i++) p.push_back(8'(i * 7 + 3));
    model_rx(p, 1508, 1'b0, 1'b1);
    send_pkt(p, 16'd1508);
    wait_done("t2");
    chk("t2_trunc_literal", trunc, 1);
`ifdef UDP_ECHO_LEN_CHECK_EN
    chk("t2_drop_literal", drop_cnt, 1);
    chk("t2_rx_literal", rx_pkt_cnt, 1);
`else
    chk("t2_blen_literal", last_blen, 1472);
    chk("t2_len_literal", app_data_length, 1472);
`endif
    check_cnt("t2");

    // 3: second packet during SEND is ignored; third after IDLE is echoed
    p = {};
    for (int i = 0; i < 30; i++) p.push_back(8'(8'h30 + i));
    model_rx(p, 38, 1'b0, 1'b1);
    send_pkt(p, 16'd38);
    wait_strobe("t3");
    p = {};
    for (int i = 0; i < 10; i++) p.push_back(8'(8'hC0 + i));
    model_rx(p, 18, 1'b1, 1'b1);
    send_pkt(p, 16'd18);
    wait_done("t3a");
    p = {};
    for (int i = 0; i < 12; i++) p.push_back(8'(8'h90 ^ i));
    model_rx(p, 20, 1'b0, 1'b1);
    send_pkt(p, 16'd20);
    wait_done("t3c");
    chk("t3_blen_literal", last_blen, 12);
    check_cnt("t3");

    // 4: no ack -> request withdrawn after TMO cycles, then normal echo
    ack_en = 1'b0;
    p = {};
    for (int i = 0; i < 8; i++) p.push_back(8'(8'h11 * i));
    model_rx(p, 16, 1'b0, 1'b0);
    send_pkt(p, 16'd16);
    k = 0;
    while (k < 50 && !app_data_request) begin
      @(negedge rgmii_clk);
      k++;
    end
    chk("t4_request_seen", app_data_request, 1);
    k = 0;
    while (k < TMO + 100 && app_data_request) begin
      k++;
      @(negedge rgmii_clk);
    end
    chk("t4_request_hold", k, TMO);
    repeat (3) @(negedge rgmii_clk);
    chk("t4_request_withdrawn", app_data_request, 0);
    check_cnt("t4a");
    ack_en = 1'b1;
    p = {};
    for (int i = 0; i < 6; i++) p.push_back(8'(8'hE0 + 3 * i));
    model_rx(p, 14, 1'b0, 1'b1);
    send_pkt(p, 16'd14);
    wait_done("t4b");
    check_cnt("t4b");

    // 5: reset mid-SEND
    p = {};
    for (int i = 0; i < 40; i++) p.push_back(8'(8'h55 + i));
    model_rx(p, 48, 1'b0, 1'b1);
    send_pkt(p, 16'd48);
    wait_strobe("t5");
    repeat (5) @(negedge rgmii_clk);
    chk("t5_pre_valid", app_data_in_valid, 1);
    #2 rstn = 1'b0;
    exp_q.delete();
    exp_blen.delete();
    exp_rx = 0;
    exp_drop = 0;
    exp_trunc = 1'b0;
    #1;
    chk("t5_async_valid", app_data_in_valid, 0);
    chk("t5_async_request", app_data_request, 0);
    chk("t5_async_data", app_data_in, 0);
    chk("t5_async_length", app_data_length, 0);
    chk("t5_async_rx", rx_pkt_cnt, 0);
    repeat (3) @(negedge rgmii_clk);
    #2 rstn = 1'b1;
    repeat (20) @(negedge rgmii_clk);
    check_cnt("t5a");
    p = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    model_rx(p, 12, 1'b0, 1'b1);
    send_pkt(p, 16'd12);
    wait_done("t5b");
    chk("t5_blen_literal", last_blen, 4);
    chk("t5_last_literal", last_last, 8'hEF);
    check_cnt("t5b");

    // 6: single-byte payload
    p = {8'hA5};
    model_rx(p, 9, 1'b0, 1'b1);
    send_pkt(p, 16'd9);
    wait_done("t6");
    chk("t6_len_literal", app_data_length, 1);
    chk("t6_blen_literal", last_blen, 1);
    chk("t6_byte_literal", last_first, 8'hA5);
    check_cnt("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/udp_rx_echo.md
Name: udp_rx_echo

Overview:
- Receive-side application partner for the UDP/IP/MAC stack's transmit-side test FSM.
- Captures each received UDP payload (udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length) into a single-packet byte buffer.
- Then replays the payload through the stack's app transmit handshake (app_data_request / udp_send_ack / app_data_in_valid), echoing it back to the peer.
- Sits in the rgmii_clk domain beside the UDP stack top; used for link loopback tests.

Parameters:
- MAX_LEN, 1472, maximum payload bytes stored (1500 - 20 - 8); excess bytes are discarded.
- ADDR_W, 11, buffer address width; 2**ADDR_W must be >= MAX_LEN.
- ACK_TIMEOUT, 32'd125_000, cycles to wait for udp_send_ack before abandoning the echo.

Ports:
- rgmii_clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- udp_rec_data_valid  in  1  high for each received payload byte; contiguous per packet.
- udp_rec_rdata  in  8  received payload byte.
- udp_rec_data_length  in  16  UDP length field (header + payload); valid while udp_rec_data_valid is high.
- udp_send_ack  in  1  one-cycle pulse: the stack accepts the request and is ready for payload.
- mac_send_end  in  1  one-cycle pulse: frame fully transmitted.
- app_data_request  out  1  transmit request.
- app_data_length  out  16  payload bytes to send.
- app_data_in_valid  out  1  payload byte strobe.
- app_data_in  out  8  payload byte.
- rx_pkt_cnt  out  16  packets accepted for echo.
- drop_cnt  out  16  packets dropped.
- trunc  out  1  sticky: a packet exceeded MAX_LEN.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; counters 0; trunc 0.
- Buffer: one-port-write, one-port-read byte RAM of 2**ADDR_W entries; 1-cycle read latency.
- FSM states:
  - IDLE: on the first cycle with udp_rec_data_valid=1, write that byte at address 0, set byte_cnt=1, go to RECV.
  - RECV: each valid byte is written at address byte_cnt, then byte_cnt increments, while byte_cnt < MAX_LEN.
    - Bytes arriving once byte_cnt == MAX_LEN are not written and set trunc.
    - On the first cycle with udp_rec_data_valid=0: latch app_data_length=byte_cnt, increment rx_pkt_cnt, go to REQ.
  - REQ: app_data_request=1, held continuously.
    - On udp_send_ack, drop app_data_request the next cycle and go to SEND.
    - If ACK_TIMEOUT cycles elapse with no ack, go to IDLE and increment drop_cnt.
  - SEND: read addresses 0..app_data_length-1 on consecutive cycles.
    - app_data_in_valid=1 with app_data_in=buffer[i], aligned to the read data.
    - Exactly app_data_length contiguous strobes; the first strobe follows the ack by 2 cycles.
    - After the last strobe, go to DONE.
  - DONE: wait for mac_send_end, then go to IDLE.
- Packets arriving while in REQ, SEND or DONE are ignored: nothing is written. drop_cnt increments once per packet, on the rising edge of udp_rec_data_valid.
- A packet starting in the same cycle the FSM enters IDLE is captured normally.
- app_data_length is stable from REQ entry until IDLE.
- Counters saturate at 16'hFFFF.
- Reset mid-operation aborts immediately: no further strobes, and the buffer contents are don't-care.

Optional Feature:
- Macro: UDP_ECHO_LEN_CHECK_EN.
- Defined: at the end of RECV, compare byte_cnt with udp_rec_data_length - 8, where udp_rec_data_length is sampled on the packet's first byte.
  - On mismatch, or if trunc was set for this packet: do not echo; increment drop_cnt instead of rx_pkt_cnt; return to IDLE.
- Undefined: no length check; the sampled length is unused and the packet is echoed with byte_cnt bytes, truncated if necessary.

Test Plan:
1. 20-byte payload "www.meyesemi.com   \n", length field 28, ack 5 cycles after request.
   - rx_pkt_cnt=1; app_data_length=20.
   - 20 contiguous strobes with identical bytes, starting 2 cycles after the ack.
   - After mac_send_end: state IDLE, app_data_request=0.
2. 1500-byte payload.
   - Exactly 1472 echoed bytes, equal to the first 1472 received; trunc=1.
   - With UDP_ECHO_LEN_CHECK_EN defined: no echo, drop_cnt=1.
3. Second 10-byte packet arrives while SEND is active.
   - drop_cnt=1; the first packet's echo is uncorrupted.
   - A third packet after IDLE is echoed correctly.
4. No udp_send_ack for ACK_TIMEOUT cycles.
   - Request withdrawn; drop_cnt=1; IDLE; the next packet is echoed normally.
5. Assert rstn low mid-SEND.
   - All outputs 0 asynchronously; no strobes after release; a fresh 4-byte packet echoes correctly.
6. 1-byte payload 8'hA5, length field 9.
   - app_data_length=1; a single strobe with app_data_in=8'hA5.
